// File: rtl/pio_sm_sequencer.sv
// Host-side command sequencer for the state machines of one PIO block: run enables,
// restart / divider-restart pulses and forced-instruction injection via valid/ready.
module pio_sm_sequencer #(
  parameter int NSM     = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic [2:0]     cmd_op,
  input  logic [NSM-1:0] cmd_mask,
  input  logic [15:0]    cmd_data,
  input  logic [NSM-1:0] sm_penable,
  output logic [NSM-1:0] sm_en,
  output logic [NSM-1:0] sm_restart,
  output logic [NSM-1:0] div_restart,
  output logic [NSM-1:0] sm_imm,
  output logic [15:0]    imm_instr,
  output logic           busy,
  output logic           exec_done,
  output logic           cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_PULSE, S_EXEC} state_e;
  typedef enum logic [2:0] {
    OP_ENABLE  = 3'd0,
    OP_DISABLE = 3'd1,
    OP_RESTART = 3'd2,
    OP_DIVSYNC = 3'd3,
    OP_EXEC    = 3'd4
  } op_e;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_e         state_q;
  logic [NSM-1:0] sm_en_q;
  logic [NSM-1:0] sm_restart_q;
  logic [NSM-1:0] div_restart_q;
  logic [NSM-1:0] pending_q;
  logic [15:0]    imm_instr_q;
  logic [15:0]    cnt_q;
  logic           busy_q;
  logic           exec_done_q;
  logic           cmd_err_q;

  logic [NSM-1:0] pend_rem_d;
  logic [NSM-1:0] emask_d;
  logic [15:0]    cnt_d;

  always_comb begin
    pend_rem_d = pending_q & ~sm_penable;
    emask_d    = cmd_mask & sm_en_q;
    cnt_d      = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      sm_en_q       <= '0;
      sm_restart_q  <= '0;
      div_restart_q <= '0;
      pending_q     <= '0;
      imm_instr_q   <= '0;
      cnt_q         <= '0;
      busy_q        <= 1'b0;
      exec_done_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
    end else begin
      sm_restart_q  <= '0;
      div_restart_q <= '0;
      exec_done_q   <= 1'b0;
      cmd_err_q     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              OP_ENABLE:  sm_en_q <= sm_en_q | cmd_mask;
              OP_DISABLE: sm_en_q <= sm_en_q & ~cmd_mask;
              OP_RESTART: begin
                sm_restart_q <= cmd_mask;
                state_q      <= S_PULSE;
                busy_q       <= 1'b1;
              end
              OP_DIVSYNC: begin
                div_restart_q <= cmd_mask;
                state_q       <= S_PULSE;
                busy_q        <= 1'b1;
              end
              OP_EXEC: begin
                if (emask_d == '0) begin
                  cmd_err_q <= 1'b1;
                end else begin
                  pending_q   <= emask_d;
                  imm_instr_q <= cmd_data;
                  cnt_q       <= '0;
                  state_q     <= S_EXEC;
                  busy_q      <= 1'b1;
                end
              end
              default: cmd_err_q <= 1'b1;
            endcase
          end
        end
        S_PULSE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        S_EXEC: begin
          // Completion takes priority over a timeout landing on the same cycle.
          if (pend_rem_d == '0) begin
            pending_q   <= '0;
            exec_done_q <= 1'b1;
            state_q     <= S_IDLE;
            busy_q      <= 1'b0;
          end else if (cnt_d == TIMEOUT_CNT) begin
            pending_q <= '0;
            cmd_err_q <= 1'b1;
            state_q   <= S_IDLE;
            busy_q    <= 1'b0;
          end else begin
            pending_q <= pend_rem_d;
            cnt_q     <= cnt_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // pending is only nonzero in EXEC, so it doubles as the registered imm request.
  assign sm_imm      = pending_q;
  assign cmd_ready   = (state_q == S_IDLE);
  assign sm_en       = sm_en_q;
  assign sm_restart  = sm_restart_q;
  assign div_restart = div_restart_q;
  assign imm_instr   = imm_instr_q;
  assign busy        = busy_q;
  assign exec_done   = exec_done_q;
  assign cmd_err     = cmd_err_q;

endmodule

// File: tb/tb_pio_sm_sequencer.sv
// Directed bench for pio_sm_sequencer: a transaction-level model checked every cycle,
// plus literal expectations taken from the command scenarios.
module tb_pio_sm_sequencer;

  localparam int NSM = 4;
  localparam int TO  = 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           cmd_valid = 1'b0;
  logic           cmd_ready;
  logic [2:0]     cmd_op = '0;
  logic [NSM-1:0] cmd_mask = '0;
  logic [15:0]    cmd_data = '0;
  logic [NSM-1:0] sm_penable = '0;
  logic [NSM-1:0] sm_en, sm_restart, div_restart, sm_imm;
  logic [15:0]    imm_instr;
  logic           busy, exec_done, cmd_err;

  int total = 0;
  int bad   = 0;
  bit check_en = 1'b0;

  pio_sm_sequencer #(.NSM(NSM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data),
    .sm_penable(sm_penable), .sm_en(sm_en), .sm_restart(sm_restart),
    .div_restart(div_restart), .sm_imm(sm_imm), .imm_instr(imm_instr),
    .busy(busy), .exec_done(exec_done), .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: tracks an EXEC as (targets, released-so-far, age) rather than a state register.
  logic [NSM-1:0] m_en = '0, m_rst = '0, m_div = '0, m_targets = '0, m_released = '0;
  logic [15:0]    m_instr = '0;
  bit             m_pulse = 0, m_exec = 0, m_done = 0, m_err = 0;
  int             m_age = 0;

  always @(posedge clk) begin
    m_rst = '0; m_div = '0; m_done = 0; m_err = 0;
    if (reset) begin
      m_en = '0; m_targets = '0; m_released = '0; m_instr = '0;
      m_pulse = 0; m_exec = 0; m_age = 0;
    end else if (m_exec) begin
      m_released = m_released | (sm_penable & m_targets);
      m_age++;
      if ((m_targets & ~m_released) == '0) begin
        m_exec = 0; m_done = 1;
      end else if (m_age == TO) begin
        m_exec = 0; m_err = 1;
      end
    end else if (m_pulse) begin
      m_pulse = 0;
    end else if (cmd_valid) begin
      if (cmd_op == 3'd0) m_en = m_en | cmd_mask;
      else if (cmd_op == 3'd1) m_en = m_en & ~cmd_mask;
      else if (cmd_op == 3'd2) begin m_rst = cmd_mask; m_pulse = 1; end
      else if (cmd_op == 3'd3) begin m_div = cmd_mask; m_pulse = 1; end
      else if (cmd_op == 3'd4) begin
        if ((cmd_mask & m_en) == '0) m_err = 1;
        else begin
          m_targets = cmd_mask & m_en; m_released = '0; m_age = 0;
          m_instr = cmd_data; m_exec = 1;
        end
      end else m_err = 1;
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      chk("sm_en", 32'(sm_en), 32'(m_en));
      chk("sm_restart", 32'(sm_restart), 32'(m_rst));
      chk("div_restart", 32'(div_restart), 32'(m_div));
      chk("sm_imm", 32'(sm_imm), 32'(m_exec ? (m_targets & ~m_released) : '0));
      if (m_exec) chk("imm_instr", 32'(imm_instr), 32'(m_instr));
      chk("busy", 32'(busy), 32'(m_exec || m_pulse));
      chk("cmd_ready", 32'(cmd_ready), 32'(!(m_exec || m_pulse)));
      chk("exec_done", 32'(exec_done), 32'(m_done));
      chk("cmd_err", 32'(cmd_err), 32'(m_err));
    end
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic cmd(input logic [2:0] op, input logic [NSM-1:0] mask, input logic [15:0] data);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = mask; cmd_data = data;
  endtask

  task automatic idle();
    cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_data = '0;
  endtask

  initial begin
    step(); step();
    reset = 1'b0;
    check_en = 1'b1;
    chk("rst sm_en", 32'(sm_en), 32'h0);
    chk("rst ready", 32'(cmd_ready), 32'h1);
    chk("rst busy", 32'(busy), 32'h0);
    chk("rst imm_instr", 32'(imm_instr), 32'h0);

    // ENABLE then DISABLE back to back
    cmd(3'd0, 4'b0101, '0); step();
    chk("en sm_en", 32'(sm_en), 32'h5);
    chk("en ready", 32'(cmd_ready), 32'h1);
    cmd(3'd1, 4'b0001, '0); step();
    chk("dis sm_en", 32'(sm_en), 32'h4);
    chk("dis ready", 32'(cmd_ready), 32'h1);

    // RESTART then DIVSYNC held valid across the pulse cycle
    cmd(3'd2, 4'b1010, '0); step();
    chk("rst pulse", 32'(sm_restart), 32'hA);
    chk("rst pulse ready", 32'(cmd_ready), 32'h0);
    cmd(3'd3, 4'b1111, '0); step();
    chk("rst pulse end", 32'(sm_restart), 32'h0);
    chk("div before", 32'(div_restart), 32'h0);
    chk("ready after pulse", 32'(cmd_ready), 32'h1);
    step();
    chk("div pulse", 32'(div_restart), 32'hF);
    chk("div ready", 32'(cmd_ready), 32'h0);
    idle(); step();
    chk("div pulse end", 32'(div_restart), 32'h0);

    // EXEC with staggered release
    cmd(3'd1, 4'b1111, '0); step();
    cmd(3'd0, 4'b0011, '0); step();
    chk("exec pre en", 32'(sm_en), 32'h3);
    cmd(3'd4, 4'b0011, 16'hE021); step();
    idle();
    chk("exec N+1 imm", 32'(sm_imm), 32'h3);
    chk("exec instr", 32'(imm_instr), 32'hE021);
    sm_penable = 4'b0001; step();
    chk("exec N+2 imm", 32'(sm_imm), 32'h2);
    sm_penable = 4'b0000; step();
    chk("exec N+3 imm", 32'(sm_imm), 32'h2);
    step();
    chk("exec N+4 imm", 32'(sm_imm), 32'h2);
    sm_penable = 4'b0010; step();
    sm_penable = '0;
    chk("exec N+5 imm", 32'(sm_imm), 32'h0);
    chk("exec N+5 done", 32'(exec_done), 32'h1);
    step();
    chk("exec N+6 done", 32'(exec_done), 32'h0);

    // EXEC with empty effective mask, then reserved opcode
    cmd(3'd4, 4'b1100, 16'h1234); step();
    chk("empty err", 32'(cmd_err), 32'h1);
    chk("empty imm", 32'(sm_imm), 32'h0);
    cmd(3'd6, 4'b1111, '0); step();
    chk("rsv err", 32'(cmd_err), 32'h1);
    chk("rsv sm_en", 32'(sm_en), 32'h3);
    idle(); step();

    // EXEC timeout with no penable
    cmd(3'd4, 4'b0001, 16'hA5A5); step();
    idle();
    for (int k = 0; k < TO; k++) begin
      chk("to imm", 32'(sm_imm), 32'h1);
      chk("to err early", 32'(cmd_err), 32'h0);
      step();
    end
    chk("to imm clr", 32'(sm_imm), 32'h0);
    chk("to err", 32'(cmd_err), 32'h1);
    chk("to done", 32'(exec_done), 32'h0);
    chk("to ready", 32'(cmd_ready), 32'h1);
    step();

    // EXEC where every target is released in the first cycle
    cmd(3'd4, 4'b0011, 16'h0F0F); step();
    idle();
    chk("fast imm", 32'(sm_imm), 32'h3);
    sm_penable = 4'b0011; step();
    sm_penable = '0;
    chk("fast imm clr", 32'(sm_imm), 32'h0);
    chk("fast done", 32'(exec_done), 32'h1);
    step();

    // Reset in the middle of an EXEC
    cmd(3'd4, 4'b0011, 16'hBEEF); step();
    idle();
    chk("mid imm", 32'(sm_imm), 32'h3);
    step();
    reset = 1'b1; step();
    reset = 1'b0;
    chk("mrst imm", 32'(sm_imm), 32'h0);
    chk("mrst en", 32'(sm_en), 32'h0);
    chk("mrst busy", 32'(busy), 32'h0);
    chk("mrst done", 32'(exec_done), 32'h0);
    chk("mrst err", 32'(cmd_err), 32'h0);
    step();
    chk("mrst done2", 32'(exec_done), 32'h0);
    chk("mrst err2", 32'(cmd_err), 32'h0);
    step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pio_sm_sequencer.md
# pio_sm_sequencer

Host-side command sequencer for the state machines in one PIO block. It sits between the bus/register interface and the per-machine control inputs: run enables, `restart`, clock-divider restart and forced-instruction (`imm`) injection. Commands are accepted one at a time through a valid/ready handshake. Forced instructions are held until every targeted machine has consumed one divided clock enable.

## Interface
Parameters:
- `NSM`, default 4: number of state machines controlled.
- `TIMEOUT`, default 1023: maximum cycles an EXEC command may wait before it is aborted. Range 1..65535.

Ports:
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `cmd_valid` in 1: command present.
- `cmd_ready` out 1: sequencer can accept a command.
- `cmd_op` in 3: opcode.
  - 0 ENABLE
  - 1 DISABLE
  - 2 RESTART
  - 3 DIVSYNC
  - 4 EXEC
  - 5-7 reserved
- `cmd_mask` in NSM: target machines, bit i = machine i.
- `cmd_data` in 16: instruction word (EXEC only).
- `sm_penable` in NSM: divided clock enable of each machine.
- `sm_en` out NSM: run enable per machine.
- `sm_restart` out NSM: one-cycle restart pulse per machine.
- `div_restart` out NSM: one-cycle divider restart pulse per machine.
- `sm_imm` out NSM: forced-instruction request per machine.
- `imm_instr` out 16: instruction driven while any `sm_imm` bit is high.
- `busy` out 1: state is not IDLE.
- `exec_done` out 1: one-cycle pulse when EXEC completes.
- `cmd_err` out 1: one-cycle pulse for a reserved opcode, an EXEC with empty effective mask, or an EXEC timeout.

## Operation
- States: IDLE, PULSE, EXEC.
- `cmd_ready = (state == IDLE)`.
- A command is accepted on a cycle with `cmd_valid & cmd_ready`. `cmd_op`, `cmd_mask` and `cmd_data` are sampled only at acceptance.

Per-opcode behaviour on acceptance:
- ENABLE: `sm_en <= sm_en | mask`; stay IDLE.
- DISABLE: `sm_en <= sm_en & ~mask`; stay IDLE.
- RESTART: next cycle `sm_restart = mask`, state PULSE. PULSE lasts exactly one cycle, then IDLE.
- DIVSYNC: same as RESTART but drives `div_restart`. All masked dividers restart on the same cycle.
- RESTART and DIVSYNC with an all-zero mask still take the PULSE cycle, with all pulse outputs 0.
- EXEC:
  - Effective mask `emask = cmd_mask & sm_en`.
  - If `emask == 0`: `cmd_err` pulses next cycle, stay IDLE, no `imm`.
  - Otherwise latch `pending <= emask` and `imm_instr <= cmd_data`, load the timeout counter to 0, go to EXEC.
- Reserved ops 5-7: accepted, `cmd_err` pulses next cycle, no other effect.

In EXEC:
- `sm_imm = pending`.
- Each cycle, `pending <= pending & ~sm_penable`.
- When `pending & ~sm_penable == 0`: `exec_done` pulses next cycle and state returns to IDLE.
- The counter increments each EXEC cycle. If it reaches TIMEOUT with pending nonzero: `pending <= 0`, `cmd_err` pulses, state returns to IDLE, and `exec_done` does not pulse.

Other rules:
- `imm_instr` holds its last value after EXEC. It is meaningful only while `sm_imm != 0`.
- `sm_en` cannot change during EXEC because no command is accepted. Disabling a machine therefore never orphans a pending bit.

## Timing
- Reset values: `sm_en`, `sm_restart`, `div_restart`, `sm_imm`, `pending` = 0. `imm_instr` = 0, `busy` = 0, `exec_done` = 0, `cmd_err` = 0. State IDLE, so `cmd_ready` = 1.
- Reset mid-operation: on the next edge all outputs take their reset values. Any active `sm_imm`, pulse or pending EXEC is dropped without `exec_done` or `cmd_err`.
- ENABLE/DISABLE: new `sm_en` is visible 1 cycle after acceptance. `cmd_ready` stays high, giving back-to-back throughput of 1 command per cycle.
- RESTART/DIVSYNC: pulse is high in cycle N+1 for acceptance in cycle N; `cmd_ready` is low in N+1 and high in N+2.
- EXEC:
  - `sm_imm[i]` rises in cycle N+1.
  - It stays high up to and including the first cycle in which `sm_penable[i]=1`, and is low on the following cycle.
  - If all targeted `sm_penable` bits are high in N+1, `sm_imm` is high for exactly 1 cycle and `exec_done` pulses in N+2.
  - Machines are released independently: bits drop at different cycles.
- `busy` is all-registered from state. `cmd_ready` is combinational from state only; there is no combinational path from `cmd_valid` to `cmd_ready`.
- `exec_done` and `cmd_err` are never high in the same cycle.

## Test plan
- Reset, then ENABLE mask 0101 followed on the next cycle by DISABLE mask 0001 -> `sm_en` reads 0101, then 0100; `cmd_ready` stays 1 throughout.
- RESTART mask 1010 accepted at cycle 10 -> `sm_restart=1010` only in cycle 11; `cmd_ready=0` in cycle 11; a DIVSYNC 1111 held valid is accepted in cycle 12 and `div_restart=1111` appears only in cycle 13.
- EXEC `cmd_data=0xE021` to mask 0011 with `sm_en=0011`, `sm_penable[0]` high in cycle N+1 and `sm_penable[1]` high in N+4:
  - `sm_imm` reads 0011 in N+1, then 0010 in N+2..N+4, then 0000.
  - `imm_instr=0xE021`; `exec_done` pulses in N+5.
- EXEC to mask 1100 with `sm_en=0011` -> no `sm_imm`; `cmd_err` pulses 1 cycle later. Opcode 6 -> `cmd_err` pulse, `sm_en` unchanged.
- EXEC with TIMEOUT=8 and `sm_penable` held 0 -> `sm_imm` is high for 8 cycles, then clears; `cmd_err` pulses; no `exec_done`; `cmd_ready` returns to 1.
- Reset asserted for 1 cycle in the middle of an EXEC -> `sm_imm`, `sm_en` and `busy` are 0 on the next cycle; no `exec_done` or `cmd_err` pulse.
